rrf_nwide: RTL and testbench

- N-wide retirement register file holding committed arch→phys mappings.
- Accepts COMMIT_WIDTH in-order commits per cycle.
- Returns per-lane old physical register for freeing, with intra-group WAW forwarding.
- Contains a multi-cycle restore engine that streams the committed map back to the speculative RAT after a flush, RESTORE_LANES entries per beat. Sits between ROB commit stage and free list / RAT.

---
 rtl/rrf_nwide.sv | 145 ++++++++++++++
 tb/tb_rrf_nwide.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rrf_nwide.sv
// Retirement register file: committed arch->phys map with N-wide in-order
// commit, per-lane old-mapping return for freeing (with intra-group WAW
// forwarding), and a multi-beat restore engine that streams the committed
// map back to the speculative RAT.
module rrf_nwide #(
  parameter int NUM_AREGS     = 32,
  parameter int NUM_PREGS     = 64,
  parameter int COMMIT_WIDTH  = 2,
  parameter int RESTORE_LANES = 8,
  localparam int AW    = $clog2(NUM_AREGS),
  localparam int PW    = $clog2(NUM_PREGS),
  localparam int BEATS = NUM_AREGS / RESTORE_LANES,
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          commit_ready,
  input  logic [COMMIT_WIDTH-1:0]       commit_en,
  input  logic [COMMIT_WIDTH*AW-1:0]    commit_areg,
  input  logic [COMMIT_WIDTH*PW-1:0]    commit_preg,
  output logic [COMMIT_WIDTH-1:0]       free_valid,
  output logic [COMMIT_WIDTH*PW-1:0]    old_preg,
  input  logic                          restore_req,
  output logic                          restore_busy,
  output logic                          restore_valid,
  output logic [AW-1:0]                 restore_base,
  output logic [RESTORE_LANES*PW-1:0]   restore_map,
  output logic                          restore_done
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_RESTORE = 1'b1;

  logic [PW-1:0]              table_q [NUM_AREGS];
  logic [PW-1:0]              table_d [NUM_AREGS];
  logic [0:0]                 state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       restore_valid_q, restore_valid_d;
  logic                       restore_done_q, restore_done_d;
  logic [AW-1:0]              restore_base_q, restore_base_d;
  logic [RESTORE_LANES*PW-1:0] restore_map_q, restore_map_d;

  assign commit_ready  = (state_q == S_IDLE);
  assign restore_busy  = (state_q == S_RESTORE);
  assign restore_valid = restore_valid_q;
  assign restore_done  = restore_done_q;
  assign restore_base  = restore_base_q;
  assign restore_map   = restore_map_q;

  // Old mapping per lane: youngest older lane writing the same areg wins over the table.
  always_comb begin
    logic [AW-1:0] ar_k;
    logic [PW-1:0] op_k;
    old_preg   = '0;
    free_valid = '0;
    ar_k       = '0;
    op_k       = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      ar_k = commit_areg[k*AW +: AW];
      op_k = table_q[ar_k];
      for (int j = 0; j < k; j++) begin
        if (commit_en[j] && commit_ready && (ar_k != '0) &&
            (commit_areg[j*AW +: AW] == ar_k)) begin
          op_k = commit_preg[j*PW +: PW];
        end
      end
      old_preg[k*PW +: PW] = op_k;
      free_valid[k]        = commit_en[k] && commit_ready && (ar_k != '0);
    end
  end

  // Next table: lanes applied oldest to youngest so the highest lane wins; areg 0 is never written.
  always_comb begin
    table_d = table_q;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (commit_en[k] && commit_ready && (commit_areg[k*AW +: AW] != '0)) begin
        table_d[commit_areg[k*AW +: AW]] = commit_preg[k*PW +: PW];
      end
    end
  end

  // Restore sequencer and next-beat outputs; beats read table_d so same-cycle commits are streamed.
  always_comb begin
    logic [AW-1:0] idx;
    state_d = state_q;
    cnt_d   = cnt_q;
    idx     = '0;
    case (state_q)
      S_IDLE: begin
        if (restore_req) begin
          state_d = S_RESTORE;
          cnt_d   = '0;
        end
      end
      S_RESTORE: begin
        if (cnt_q == CW'(BEATS - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    restore_valid_d = (state_d == S_RESTORE);
    restore_done_d  = (state_d == S_RESTORE) && (cnt_d == CW'(BEATS - 1));
    restore_base_d  = AW'(int'(cnt_d) * RESTORE_LANES);
    restore_map_d   = '0;
    for (int l = 0; l < RESTORE_LANES; l++) begin
      idx = AW'(int'(cnt_d) * RESTORE_LANES + l);
      restore_map_d[l*PW +: PW] = table_d[idx];
    end
  end

  // Control state and the committed table; reset restores the identity map.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      restore_valid_q <= 1'b0;
      restore_done_q  <= 1'b0;
      for (int i = 0; i < NUM_AREGS; i++) begin
        table_q[i] <= PW'(i);
      end
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      restore_valid_q <= restore_valid_d;
      restore_done_q  <= restore_done_d;
      for (int i = 0; i < NUM_AREGS; i++) begin
        table_q[i] <= table_d[i];
      end
    end
  end

  // Restore beat payload; only meaningful while restore_valid is high.
  always_ff @(posedge clk) begin
    restore_base_q <= restore_base_d;
    restore_map_q  <= restore_map_d;
  end

endmodule

// File: tb/tb_rrf_nwide.sv
// Directed bench for rrf_nwide: reference map model plus a beat scoreboard.
module tb_rrf_nwide;
  localparam int NA = 32;
  localparam int NP = 64;
  localparam int CWD = 2;
  localparam int RL = 8;
  localparam int AW = 5;
  localparam int PW = 6;
  localparam int BEATS = NA / RL;

  logic              clk = 1'b0;
  logic              rst;
  logic              commit_ready;
  logic [CWD-1:0]    commit_en;
  logic [CWD*AW-1:0] commit_areg;
  logic [CWD*PW-1:0] commit_preg;
  logic [CWD-1:0]    free_valid;
  logic [CWD*PW-1:0] old_preg;
  logic              restore_req;
  logic              restore_busy;
  logic              restore_valid;
  logic [AW-1:0]     restore_base;
  logic [RL*PW-1:0]  restore_map;
  logic              restore_done;

  rrf_nwide #(.NUM_AREGS(NA), .NUM_PREGS(NP), .COMMIT_WIDTH(CWD), .RESTORE_LANES(RL)) dut (
    .clk(clk), .rst(rst), .commit_ready(commit_ready), .commit_en(commit_en),
    .commit_areg(commit_areg), .commit_preg(commit_preg), .free_valid(free_valid),
    .old_preg(old_preg), .restore_req(restore_req), .restore_busy(restore_busy),
    .restore_valid(restore_valid), .restore_base(restore_base),
    .restore_map(restore_map), .restore_done(restore_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]    base;
    logic [RL*PW-1:0] map;
    logic             done;
  } beat_t;

  beat_t         sb[$];
  logic [PW-1:0] tbl [NA];
  int            nvec = 0;
  int            nerr = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) tbl[i] = PW'(i);
  endtask

  // Push the full expected stream for the current model contents.
  task automatic push_stream();
    beat_t b;
    for (int k = 0; k < BEATS; k++) begin
      b.base = AW'(k * RL);
      b.map  = '0;
      for (int i = 0; i < RL; i++) b.map[i*PW +: PW] = tbl[k*RL + i];
      b.done = (k == BEATS - 1);
      sb.push_back(b);
    end
  endtask

  // Drive a commit group (caller ticks); checks old_preg/free_valid and updates the model.
  task automatic drive_commit(input logic [CWD-1:0] en, input logic [CWD*AW-1:0] ar,
                              input logic [CWD*PW-1:0] pr, input string tag);
    logic [CWD*PW-1:0] exp_old;
    logic [CWD-1:0]    exp_fv;
    logic [AW-1:0]     a;
    commit_en = en; commit_areg = ar; commit_preg = pr;
    #1;
    exp_old = '0; exp_fv = '0;
    for (int k = 0; k < CWD; k++) begin
      a = ar[k*AW +: AW];
      exp_old[k*PW +: PW] = tbl[a];
      exp_fv[k] = en[k] && (a != '0);
      if (en[k] && a != '0) tbl[a] = pr[k*PW +: PW];
    end
    check({tag, ".old_preg"}, 64'(old_preg), 64'(exp_old));
    check({tag, ".free_valid"}, 64'(free_valid), 64'(exp_fv));
  endtask

  // Request a restore (optionally with a same-cycle commit) and score the stream.
  task automatic do_restore(input logic [CWD-1:0] en, input logic [CWD*AW-1:0] ar,
                            input logic [CWD*PW-1:0] pr, input bit junk, input string tag);
    beat_t b;
    int    busy_cycles;
    check({tag, ".ready_before"}, 64'(commit_ready), 64'd1);
    restore_req = 1'b1;
    drive_commit(en, ar, pr, {tag, ".req_commit"});
    push_stream();
    tick();
    restore_req = 1'b0;
    commit_en   = '0;
    busy_cycles = 0;
    for (int c = 0; c < BEATS + 4; c++) begin
      if (commit_ready === 1'b0) busy_cycles++;
      if (restore_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check({tag, ".extra_beat"}, 64'd1, 64'd0);
        end else begin
          b = sb.pop_front();
          check({tag, ".base"}, 64'(restore_base), 64'(b.base));
          check({tag, ".map"}, 64'(restore_map), 64'(b.map));
          check({tag, ".done"}, 64'(restore_done), 64'(b.done));
          check({tag, ".busy"}, 64'(restore_busy), 64'd1);
        end
        if (junk) begin
          commit_en = 2'b11; commit_areg = {5'd9, 5'd9}; commit_preg = {6'd60, 6'd61};
          #1;
          check({tag, ".junk_free_valid"}, 64'(free_valid), 64'd0);
        end
      end
      tick();
      commit_en = '0;
    end
    check({tag, ".beats_left"}, 64'(sb.size()), 64'd0);
    check({tag, ".ready_low_cycles"}, 64'(busy_cycles), 64'(BEATS));
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbeats;
    rst = 1'b1; restore_req = 1'b0;
    commit_en = '0; commit_areg = '0; commit_preg = '0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    #1;
    check("reset.ready", 64'(commit_ready), 64'd1);
    check("reset.valid", 64'(restore_valid), 64'd0);
    check("reset.busy", 64'(restore_busy), 64'd0);
    check("reset.done", 64'(restore_done), 64'd0);

    // Identity stream straight out of reset.
    do_restore('0, '0, '0, 1'b0, "ident");

    // Single commit lane 0: areg 5 -> 40.
    drive_commit(2'b01, {5'd0, 5'd5}, {6'd0, 6'd40}, "single");
    tick(); commit_en = '0;
    do_restore('0, '0, '0, 1'b0, "single_rs");

    // Same-areg pair in one group: 7 -> 33 then 7 -> 34.
    drive_commit(2'b11, {5'd7, 5'd7}, {6'd34, 6'd33}, "waw");
    tick(); commit_en = '0;

    // Areg 0 on lane 0 is dropped; lane 1 areg 3 -> 51.
    drive_commit(2'b11, {5'd3, 5'd0}, {6'd51, 6'd50}, "areg0");
    tick(); commit_en = '0;

    // Follow-up commits re-read the updated entries (checks table[7]=34, table[3]=51, table[0]=0).
    drive_commit(2'b11, {5'd3, 5'd7}, {6'd20, 6'd21}, "reread");
    tick(); commit_en = '0;
    drive_commit(2'b01, {5'd0, 5'd0}, {6'd0, 6'd9}, "areg0_again");
    tick(); commit_en = '0;

    // Commit 9 -> 45 together with restore_req; junk commits during the stream are dropped.
    do_restore(2'b01, {5'd0, 5'd9}, {6'd0, 6'd45}, 1'b1, "req_commit");
    do_restore('0, '0, '0, 1'b0, "after_junk");

    // restore_req held high: two streams separated by one idle cycle.
    restore_req = 1'b1;
    tick();
    nbeats = 0;
    for (int c = 0; c < 2 * BEATS + 1; c++) begin
      if (c == BEATS) begin
        check("hold.gap_valid", 64'(restore_valid), 64'd0);
        check("hold.gap_ready", 64'(commit_ready), 64'd1);
      end else if (restore_valid === 1'b1) begin
        nbeats++;
      end
      if (c == 2 * BEATS - 1) restore_req = 1'b0;
      tick();
    end
    check("hold.beats", 64'(nbeats), 64'(2 * BEATS));
    tick(); tick();

    // Reset during beat 2 aborts the stream and restores the identity map.
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    tick(); tick();
    check("abort.beat2_valid", 64'(restore_valid), 64'd1);
    check("abort.beat2_base", 64'(restore_base), 64'd16);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.valid", 64'(restore_valid), 64'd0);
    check("abort.done", 64'(restore_done), 64'd0);
    check("abort.ready", 64'(commit_ready), 64'd1);
    check("abort.busy", 64'(restore_busy), 64'd0);
    model_reset();
    do_restore('0, '0, '0, 1'b0, "abort_ident");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
